// File: rtl/spi_mnrch.sv
// SPI initiator for the inertial sensor link: one 16-bit full-duplex CPOL=1/CPHA=1 transfer per wrt.
// Optional build macro SPI_MNRCH_OVR_EN adds the ovr output (pulses after a wrt that arrives while busy).
module spi_mnrch #(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
`ifdef SPI_MNRCH_OVR_EN
    ,
    output logic        ovr
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        TRMT = 1'b1
    } state_t;

    // Idle load keeps SCLK high and places the front-porch fall a quarter period after SS_n drops.
    localparam logic [SCLK_DIV_W-1:0] DIV_IDLE  = {1'b1, 1'b0, {(SCLK_DIV_W-2){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_START = DIV_IDLE + 1'b1;
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE  = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL  = {SCLK_DIV_W{1'b1}};

    state_t                  state_q, state_d;
    logic [SCLK_DIV_W-1:0]   sclk_div_q, sclk_div_d;
    logic [15:0]             shft_q, shft_d;
    logic                    smpl_q, smpl_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    first_q, first_d;
    logic                    ss_n_q, ss_n_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sclk_div_q <= DIV_IDLE;
            shft_q     <= '0;
            smpl_q     <= 1'b0;
            bit_cnt_q  <= '0;
            first_q    <= 1'b0;
            ss_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_div_q <= sclk_div_d;
            shft_q     <= shft_d;
            smpl_q     <= smpl_d;
            bit_cnt_q  <= bit_cnt_d;
            first_q    <= first_d;
            ss_n_q     <= ss_n_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sclk_div_d = sclk_div_q;
        shft_d     = shft_q;
        smpl_d     = smpl_q;
        bit_cnt_d  = bit_cnt_q;
        first_d    = first_q;
        ss_n_d     = ss_n_q;
        done_d     = done_q;
        case (state_q)
            IDLE: begin
                sclk_div_d = DIV_IDLE;
                if (wrt) begin
                    shft_d     = wt_data;
                    bit_cnt_d  = 4'd0;
                    first_d    = 1'b1;
                    ss_n_d     = 1'b0;
                    done_d     = 1'b0;
                    sclk_div_d = DIV_START;
                    state_d    = TRMT;
                end
            end
            TRMT: begin
                sclk_div_d = sclk_div_q + 1'b1;
                if (sclk_div_q == DIV_RISE) begin
                    smpl_d = MISO;
                end
                if (sclk_div_q == DIV_FALL) begin
                    if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        shft_d = {shft_q[14:0], smpl_q};
                        if (bit_cnt_q == 4'd15) begin
                            // Last shift: reload the divider so SCLK never produces a 17th fall.
                            ss_n_d     = 1'b1;
                            done_d     = 1'b1;
                            sclk_div_d = DIV_IDLE;
                            state_d    = IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SPI_MNRCH_OVR_EN
    logic ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= wrt && (state_q != IDLE);
        end
    end

    assign ovr = ovr_q;
`endif

    assign SS_n    = ss_n_q;
    assign SCLK    = sclk_div_q[SCLK_DIV_W-1];
    assign MOSI    = shft_q[15];
    assign done    = done_q;
    assign rd_data = shft_q;

endmodule

// File: tb/tb_spi_mnrch.sv
// Bench for spi_mnrch: transaction-level reference model, per-cycle compare, responder model and directed checks.
module tb_spi_mnrch;

    logic        clk;
    logic        rst;
    logic        wrt;
    logic [15:0] wt_data;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        done;
    logic [15:0] rd_data;
`ifdef SPI_MNRCH_OVR_EN
    logic        ovr;
`endif

    spi_mnrch #(.SCLK_DIV_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .wt_data (wt_data),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (done),
        .rd_data (rd_data)
`ifdef SPI_MNRCH_OVR_EN
        ,
        .ovr     (ovr)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;
    logic [15:0] resp_word = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer lasts 520 clk after acceptance; k counts clk since the accepting edge.
    logic        m_busy = 1'b0;
    int          m_k = 0;
    logic [15:0] m_tx = 16'h0;
    logic [15:0] m_rx = 16'h0;
    logic [15:0] m_rd = 16'h0;
    logic        m_done = 1'b0;
`ifdef SPI_MNRCH_OVR_EN
    logic        m_ovr = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rd   <= 16'h0;
        end else if (m_busy) begin
            if (m_k == 519) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_rd   <= m_rx;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (wrt) begin
            m_busy <= 1'b1;
            m_k    <= 0;
            m_tx   <= wt_data;
            m_rx   <= resp_word;
            m_done <= 1'b0;
        end
`ifdef SPI_MNRCH_OVR_EN
        m_ovr <= !rst && wrt && m_busy;
`endif
    end

    // Responder: presents MSB when selected, shifts MISO on SCLK falls after a rise, samples MOSI on rises.
    logic [15:0] rcv_word = 16'h0;
    int          rcv_rises = 0;
    initial begin
        logic [15:0] rcv;
        int          rises;
        logic        pss, psc;
        rcv = 16'h0;
        rises = 0;
        pss = 1'b1;
        psc = 1'b1;
        MISO = 1'b1;
        forever begin
            @(SS_n or SCLK);
            if (pss === 1'b1 && SS_n === 1'b0) begin
                rises = 0;
                rcv = 16'h0;
                MISO = resp_word[15];
            end else if (pss === 1'b0 && SS_n === 1'b1) begin
                rcv_word = rcv;
                rcv_rises = rises;
            end else if (SS_n === 1'b0) begin
                if (psc === 1'b0 && SCLK === 1'b1) begin
                    rcv = {rcv[14:0], MOSI};
                    rises++;
                end else if (psc === 1'b1 && SCLK === 1'b0 && rises > 0 && rises < 16) begin
                    MISO = resp_word[15 - rises];
                end
            end
            pss = SS_n;
            psc = SCLK;
        end
    end

    // Per-cycle compare against the model, plus edge-timing measurements.
    int ss_fall_at = 0, ss_rise_at = 0, first_fall_at = 0, second_fall_at = 0;
    int last_rise_at = 0, meas_rises = 0, meas_falls = 0, ovr_seen = 0;
    initial begin
        int          ncyc;
        int          n;
        logic        pss, psc;
        logic        e_ss, e_sclk;
        logic [15:0] e_sh;
        logic [31:0] both;
        ncyc = 0;
        pss = 1'b1;
        psc = 1'b1;
        forever begin
            @(negedge clk);
            if (m_busy) begin
                e_ss   = 1'b0;
                e_sclk = (m_k < 8) ? 1'b1 : ((((m_k - 8) % 32) < 16) ? 1'b0 : 1'b1);
                n      = (m_k < 40) ? 0 : ((m_k - 40) / 32 + 1);
                both   = {m_tx, m_rx} >> (16 - n);
                e_sh   = both[15:0];
            end else begin
                e_ss   = 1'b1;
                e_sclk = 1'b1;
                e_sh   = m_rd;
            end
            if (chk_en) begin
                chk("SS_n", {31'b0, SS_n}, {31'b0, e_ss});
                chk("SCLK", {31'b0, SCLK}, {31'b0, e_sclk});
                chk("MOSI", {31'b0, MOSI}, {31'b0, e_sh[15]});
                chk("done", {31'b0, done}, {31'b0, m_done});
                chk("rd_data", {16'b0, rd_data}, {16'b0, e_sh});
`ifdef SPI_MNRCH_OVR_EN
                chk("ovr", {31'b0, ovr}, {31'b0, m_ovr});
                if (ovr === 1'b1) ovr_seen++;
`endif
            end
            if (pss === 1'b1 && SS_n === 1'b0) begin
                ss_fall_at = ncyc;
                meas_falls = 0;
                meas_rises = 0;
            end
            if (pss === 1'b0 && SS_n === 1'b1) ss_rise_at = ncyc;
            if (SS_n === 1'b0 && psc === 1'b1 && SCLK === 1'b0) begin
                meas_falls++;
                if (meas_falls == 1) first_fall_at = ncyc;
                if (meas_falls == 2) second_fall_at = ncyc;
            end
            if (SS_n === 1'b0 && psc === 1'b0 && SCLK === 1'b1) begin
                meas_rises++;
                last_rise_at = ncyc;
            end
            pss = SS_n;
            psc = SCLK;
            ncyc++;
        end
    end

    task automatic start(input logic [15:0] d, input logic [15:0] r);
        resp_word = r;
        wt_data = d;
        wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("done_reached", {31'b0, done}, 32'd1);
    endtask

    initial begin
        int ovr_before;
        rst = 1'b1;
        wrt = 1'b0;
        wt_data = 16'h0;
        // Test 1: reset state
        repeat (2) @(negedge clk);
        chk("rst_SS_n", {31'b0, SS_n}, 32'd1);
        chk("rst_SCLK", {31'b0, SCLK}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_rd_data", {16'b0, rd_data}, 32'h0000);
        chk("rst_MOSI", {31'b0, MOSI}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Tests 2 and 3: single transfer and edge timing
        start(16'h8F00, 16'hA5C3);
        wait_done(600);
        repeat (2) @(negedge clk);
        chk("t2_rcv", {16'b0, rcv_word}, 32'h8F00);
        chk("t2_rd_data", {16'b0, rd_data}, 32'hA5C3);
        chk("t2_done", {31'b0, done}, 32'd1);
        chk("t2_ss_low", ss_rise_at - ss_fall_at, 32'd520);
        chk("t2_rises", meas_rises, 32'd16);
        chk("t2_resp_rises", rcv_rises, 32'd16);
        chk("t3_first_fall", first_fall_at - ss_fall_at, 32'd8);
        chk("t3_period", second_fall_at - first_fall_at, 32'd32);
        chk("t3_back_porch", ss_rise_at - last_rise_at, 32'd16);

        // Test 4: wrt while busy is ignored
        ovr_before = ovr_seen;
        start(16'h1234, 16'h5AF0);
        repeat (199) @(negedge clk);
        wt_data = 16'hFFFF;
        wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        wait_done(600);
        repeat (2) @(negedge clk);
        chk("t4_rcv", {16'b0, rcv_word}, 32'h1234);
        chk("t4_rd_data", {16'b0, rd_data}, 32'h5AF0);
        chk("t4_ss_low", ss_rise_at - ss_fall_at, 32'd520);
`ifdef SPI_MNRCH_OVR_EN
        chk("t4_ovr_pulses", ovr_seen - ovr_before, 32'd1);
`endif

        // Test 5: reset mid-transfer, then a clean transfer
        start(16'hCAFE, 16'h1111);
        repeat (299) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_SS_n", {31'b0, SS_n}, 32'd1);
        chk("t5_SCLK", {31'b0, SCLK}, 32'd1);
        chk("t5_done", {31'b0, done}, 32'd0);
        chk("t5_rd_data", {16'b0, rd_data}, 32'h0000);
        rst = 1'b0;
        @(negedge clk);
        start(16'h00FF, 16'h3C96);
        wait_done(600);
        repeat (2) @(negedge clk);
        chk("t5_rcv", {16'b0, rcv_word}, 32'h00FF);
        chk("t5_rd_after", {16'b0, rd_data}, 32'h3C96);

        // Test 6: back-to-back, second wrt one clk after done rises
        start(16'h0001, 16'hF00D);
        wait_done(600);
        chk("t6a_rd_data", {16'b0, rd_data}, 32'hF00D);
        chk("t6a_rcv", {16'b0, rcv_word}, 32'h0001);
        start(16'h8000, 16'h0BAD);
        chk("t6_done_drop", {31'b0, done}, 32'd0);
        chk("t6_SS_n_low", {31'b0, SS_n}, 32'd0);
        wait_done(600);
        repeat (2) @(negedge clk);
        chk("t6b_rd_data", {16'b0, rd_data}, 32'h0BAD);
        chk("t6b_rcv", {16'b0, rcv_word}, 32'h8000);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_mnrch.md
# spi_mnrch

SPI initiator (monarch) for the inertial sensor link. It runs one 16-bit full-duplex transaction per `wrt` request. It drives `SS_n`, `SCLK` and `MOSI`, and captures `MISO`. It sits between the inertial interface logic and the iNEMO sensor, whose responder side is modelled in the Knight physics testbench. The responder shifts on the falling edge of `SCLK` and samples on the rising edge, so this block uses the same clocking: `SCLK` idles high (CPOL=1, CPHA=1).

## Interface

Parameters:
- `SCLK_DIV_W`, default 5: `SCLK` divider width. The `SCLK` period is `2^SCLK_DIV_W` clk (32 clk = 1.5625 MHz at 50 MHz). Legal range is 3 or more.

Ports (one clock; reset is synchronous and active-high):
- `clk` — in — 1 — 50 MHz system clock; all logic is on its rising edge.
- `rst` — in — 1 — synchronous, active-high reset.
- `wrt` — in — 1 — one-clk pulse that starts a transaction; sampled only in IDLE.
- `wt_data` — in — 16 — command/data to send, MSB first; captured on the accepted `wrt`.
- `MISO` — in — 1 — serial data from the sensor.
- `SS_n` — out — 1 — active-low slave select; registered.
- `SCLK` — out — 1 — serial clock; equals the MSB of the divider.
- `MOSI` — out — 1 — serial data to the sensor; equals `shft_reg[15]`.
- `done` — out — 1 — level signal: set when a transaction completes, cleared by the next accepted `wrt`; registered.
- `rd_data` — out — 16 — bits received in the last transaction; equals `shft_reg`.
- `ovr` — out — 1 — present only with `SPI_MNRCH_OVR_EN` (see Configuration).

## Operation

Datapath:
- `sclk_div`: `SCLK_DIV_W`-bit counter; `SCLK = sclk_div[MSB]`.
- `shft_reg`: 16-bit shift register.
- `MISO_smpl`: 1-bit capture flop.
- `bit_cnt`: 4-bit counter.
- `first`: flag that marks the front-porch falling edge.

State machine:
- **IDLE**
  - `sclk_div` is held at `{1,0,1…1}` (5'b10111 for W=5), so `SCLK` stays 1.
  - `SS_n` = 1.
  - On `wrt`:
    - `shft_reg` ← `wt_data`; `bit_cnt` ← 0; `first` ← 1.
    - `SS_n` ← 0; `done` ← 0.
    - Next state: TRMT.
- **TRMT**: `sclk_div` increments every clk.
  - Rise imminent (`sclk_div` = 0111…1): `MISO_smpl` ← `MISO`.
  - Fall imminent (`sclk_div` = all ones) with `first` = 1: clear `first`, no shift. This is the front porch; `MOSI` already presents bit 15.
  - Fall imminent with `first` = 0 and `bit_cnt` < 15:
    - `shft_reg` ← `{shft_reg[14:0], MISO_smpl}`.
    - `bit_cnt`++.
  - Fall imminent with `first` = 0 and `bit_cnt` = 15:
    - Perform the final shift.
    - `SS_n` ← 1; `done` ← 1.
    - `sclk_div` ← IDLE load value; `SCLK` stays high, so no 17th fall.
    - Next state: IDLE.
- Exactly 16 rising `SCLK` edges occur per transaction. The first received bit lands in `shft_reg[0]` and ends in `rd_data[15]`.

Boundary conditions:
- `wrt` asserted in TRMT is ignored. `wt_data` is not re-captured and the transaction is unaffected.
- `wrt` in the same clk as completion is ignored, because the FSM is not yet in IDLE. A `wrt` one clk later is accepted.
- `rst` at any time, including mid-transaction, takes effect at the next clk edge:
  - FSM ← IDLE; `SS_n` = 1; `SCLK` = 1.
  - `done` = 0; `shft_reg` = 0, so `MOSI` = 0 and `rd_data` = 0.
  - `bit_cnt` = 0; `ovr` = 0.
- `done` holds with `rd_data` stable until the next accepted `wrt`.

## Timing

- Latency from `wrt` to `SS_n`: `wrt` is sampled at edge E0, and `SS_n` falls after E0.
- First `SCLK` fall occurs `2^(W-2)` clk after `SS_n` falls: 8 clk for W=5.
- `SCLK` high and low phases are each `2^(W-1)` clk (16).
- `MISO` is sampled 1 clk before each `SCLK` rise.
- `MOSI` changes 0 clk after each `SCLK` fall.
- `SS_n` stays low for `2^(W-2) + 16·2^W` clk: 520 for W=5.
- `SS_n` rises and `done` rises on the same edge. That edge is `2^(W-1)` clk after the last `SCLK` rise (back porch: 16).
- The next transaction can be accepted 1 clk after `done` rises.

## Configuration

- Macro: `SPI_MNRCH_OVR_EN`.
- Defined:
  - Adds output `ovr` (1 bit, registered, reset 0).
  - `ovr` pulses high for exactly 1 clk, one clk after any `wrt` sampled while the FSM is not in IDLE.
  - Transaction behaviour is otherwise identical.
- Not defined: the `ovr` port and its logic are absent; an ignored `wrt` is silently discarded.

## Test plan

1. Reset behaviour: assert `rst` for 2 clk → `SS_n`=1, `SCLK`=1, `done`=0, `rd_data`=0x0000.
2. Single transfer: `wt_data`=0x8F00 with a behavioural responder returning 0xA5C3 → bench requires:
   - the responder receives 0x8F00;
   - `rd_data`=0xA5C3 with `done`=1;
   - `SS_n` low for exactly 520 clk;
   - exactly 16 `SCLK` rising edges.
3. Edge timing: measure from `SS_n` fall → first `SCLK` fall after 8 clk; `SCLK` period 32 clk; `SS_n` rise 16 clk after the last rise.
4. Busy `wrt`: pulse `wrt` with `wt_data`=0xFFFF at clk 200 of a 0x1234 transfer →
   - the responder still sees 0x1234;
   - `ovr` pulses once (OVR_EN build) or is absent (default build).
5. Reset mid-transfer: assert `rst` at clk 300 → next edge gives `SS_n`=1, `SCLK`=1, `done`=0. A following `wrt` of 0x00FF then completes normally with the correct `rd_data`.
6. Back-to-back transfers: issue `wrt` 1 clk after `done` rises, with 0x0001 then 0x8000 → both complete; `done` drops on the second `wrt`; `rd_data` updates per transfer.
